// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache: FSM states, the frame
// layout and the address split for the default 16-frame configuration.
package icache_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned ICACHE_SETS = 16;

  typedef enum logic {
    IDLE_ICACHE  = 1'b0,
    FETCH_ICACHE = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic        valid;
    logic [25:0] tag;
    word_t       data;
  } icache_frame_t;

  typedef struct packed {
    logic [25:0] tag;
    logic [3:0]  idx;
    logic [1:0]  bytoff;
  } icache_addr_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-port and RAM-port signals of the instruction cache; the cache is the
// slave, the datapath/memory controller side is the master.
interface icache_if;
  import icache_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-block instruction cache with a two-state
// fill FSM. Hits are combinational; misses stall until the RAM fill completes.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned SETS = ICACHE_SETS
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_if.slave     bus,
  output logic [15:0] miss_count
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            data;
  } frame_t;

  frame_t        frames_q [SETS];
  icache_state_t state_q, state_d;
  word_t         miss_addr_q, miss_addr_d;
  logic [15:0]   miss_count_q, miss_count_d;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  frame_t           sel_frame;
  logic             lookup_hit;
  logic             fill;
  logic             ihit_c;
  word_t            imemload_c;
  logic             iren_c;
  word_t            iaddr_c;
  logic             unused_offset;

  assign req_idx       = bus.imemaddr[IDX_W+1:2];
  assign req_tag       = bus.imemaddr[31:IDX_W+2];
  assign miss_idx      = miss_addr_q[IDX_W+1:2];
  assign miss_tag      = miss_addr_q[31:IDX_W+2];
  assign sel_frame     = frames_q[req_idx];
  assign lookup_hit    = sel_frame.valid && (sel_frame.tag == req_tag);
  assign unused_offset = ^bus.imemaddr[1:0];

  // Hit detection, miss capture and fill handshake; only IDLE may report a hit.
  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    miss_count_d = miss_count_q;
    fill         = 1'b0;
    ihit_c       = 1'b0;
    imemload_c   = 32'h0000_0000;
    iren_c       = 1'b0;
    iaddr_c      = 32'h0000_0000;
    case (state_q)
      IDLE_ICACHE: begin
        if (bus.imemREN) begin
          if (lookup_hit) begin
            ihit_c     = 1'b1;
            imemload_c = sel_frame.data;
          end else begin
            state_d     = FETCH_ICACHE;
            miss_addr_d = {bus.imemaddr[31:2], 2'b00};
          end
        end else begin
          state_d = IDLE_ICACHE;
        end
      end
      FETCH_ICACHE: begin
        iren_c  = 1'b1;
        iaddr_c = miss_addr_q;
        if (!bus.iwait) begin
          fill         = 1'b1;
          state_d      = IDLE_ICACHE;
          miss_count_d = miss_count_q + 16'd1;
        end else begin
          state_d = FETCH_ICACHE;
        end
      end
      default: begin
        state_d = IDLE_ICACHE;
      end
    endcase
  end

  // FSM state, miss bookkeeping and the frame array; reset clears every frame.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE_ICACHE;
      miss_addr_q  <= 32'h0000_0000;
      miss_count_q <= 16'h0000;
      for (int i = 0; i < int'(SETS); i++) begin
        frames_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      miss_count_q <= miss_count_d;
      if (fill) begin
        frames_q[miss_idx] <= {1'b1, miss_tag, bus.iload};
      end
    end
  end

  assign bus.ihit     = ihit_c;
  assign bus.imemload = imemload_c;
  assign bus.iREN     = iren_c;
  assign bus.iaddr    = iaddr_c;
  assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss latency, hits, conflict
// eviction, address change during a fill, reset mid-fill and counter wrap.
module tb_icache;
  import icache_pkg::*;

  logic        clk;
  logic        nrst;
  logic [15:0] miss_count;
  int          chk_cnt;
  int          pass_cnt;

  icache_if bus();

  icache #(.SETS(16)) dut (
    .CLK        (clk),
    .nRST       (nrst),
    .bus        (bus),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Present a missing request at the current negedge (cycle 0), hold iwait for
  // n FETCH cycles, then return data; ends at cycle n+2 where the hit shows.
  task automatic miss_fill(input string tg, input word_t addr, input int n, input word_t data);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    bus.iwait    = 1'b1;
    #1;
    chk({tg, "_c0_ihit"}, {31'd0, bus.ihit}, 32'd0);
    for (int i = 1; i <= n; i++) begin
      cyc();
      bus.iwait = 1'b1;
      #1;
      chk({tg, "_wait_iren"}, {31'd0, bus.iREN}, 32'd1);
      chk({tg, "_wait_iaddr"}, bus.iaddr, {addr[31:2], 2'b00});
    end
    cyc();
    bus.iwait = 1'b0;
    bus.iload = data;
    #1;
    chk({tg, "_done_iren"}, {31'd0, bus.iREN}, 32'd1);
    chk({tg, "_done_ihit"}, {31'd0, bus.ihit}, 32'd0);
    cyc();
    bus.iwait = 1'b1;
    bus.iload = 32'hDEAD_BEEF;
    #1;
    chk({tg, "_hit"}, {31'd0, bus.ihit}, 32'd1);
    chk({tg, "_load"}, bus.imemload, data);
    chk({tg, "_iren_idle"}, {31'd0, bus.iREN}, 32'd0);
  endtask

  initial begin
    chk_cnt      = 0;
    pass_cnt     = 0;
    nrst         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0000_0000;
    bus.iwait    = 1'b1;
    bus.iload    = 32'h0000_0000;
    #1;
    chk("rst_ihit", {31'd0, bus.ihit}, 32'd0);
    chk("rst_load", bus.imemload, 32'd0);
    chk("rst_iren", {31'd0, bus.iREN}, 32'd0);
    chk("rst_iaddr", bus.iaddr, 32'd0);
    chk("rst_cnt", {16'd0, miss_count}, 32'd0);
    cyc();
    nrst = 1'b1;
    cyc();

    // Cold miss at 0x0, iwait low in cycle 3.
    miss_fill("cold", 32'h0000_0000, 2, 32'h3C01_0001);
    chk("cold_cnt", {16'd0, miss_count}, 32'd1);

    // Idle request off, then a same-cycle hit with no RAM traffic.
    cyc();
    bus.imemREN = 1'b0;
    #1;
    chk("off_ihit", {31'd0, bus.ihit}, 32'd0);
    chk("off_load", bus.imemload, 32'd0);
    cyc();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0002;
    #1;
    chk("rehit_ihit", {31'd0, bus.ihit}, 32'd1);
    chk("rehit_load", bus.imemload, 32'h3C01_0001);
    cyc();
    #1;
    chk("rehit_iren", {31'd0, bus.iREN}, 32'd0);
    chk("rehit_cnt", {16'd0, miss_count}, 32'd1);

    // Same index, different tag evicts 0x0.
    cyc();
    miss_fill("evict", 32'h0000_0040, 0, 32'hAAAA_0040);
    chk("evict_cnt", {16'd0, miss_count}, 32'd2);
    cyc();
    miss_fill("refill", 32'h0000_0000, 1, 32'h3C01_0001);
    chk("refill_cnt", {16'd0, miss_count}, 32'd3);

    // Request changes from 0x4 to 0x80 while the 0x4 fill is outstanding.
    cyc();
    bus.imemaddr = 32'h0000_0004;
    #1;
    chk("chg_c0_ihit", {31'd0, bus.ihit}, 32'd0);
    cyc();
    bus.imemaddr = 32'h0000_0080;
    #1;
    chk("chg_c1_iaddr", bus.iaddr, 32'h0000_0004);
    chk("chg_c1_iren", {31'd0, bus.iREN}, 32'd1);
    cyc();
    bus.iwait = 1'b0;
    bus.iload = 32'h1111_0004;
    #1;
    chk("chg_c2_iaddr", bus.iaddr, 32'h0000_0004);
    chk("chg_c2_ihit", {31'd0, bus.ihit}, 32'd0);
    cyc();
    bus.iwait = 1'b1;
    #1;
    chk("chg_c3_ihit", {31'd0, bus.ihit}, 32'd0);
    chk("chg_c3_iren", {31'd0, bus.iREN}, 32'd0);
    chk("chg_c3_cnt", {16'd0, miss_count}, 32'd4);
    cyc();
    bus.iwait = 1'b0;
    bus.iload = 32'h2222_0080;
    #1;
    chk("chg_c4_iaddr", bus.iaddr, 32'h0000_0080);
    cyc();
    bus.iwait = 1'b1;
    #1;
    chk("chg_80_hit", {31'd0, bus.ihit}, 32'd1);
    chk("chg_80_load", bus.imemload, 32'h2222_0080);
    chk("chg_80_cnt", {16'd0, miss_count}, 32'd5);
    cyc();
    bus.imemaddr = 32'h0000_0004;
    #1;
    chk("chg_4_hit", {31'd0, bus.ihit}, 32'd1);
    chk("chg_4_load", bus.imemload, 32'h1111_0004);

    // Reset pulsed in the middle of a fill.
    cyc();
    bus.imemaddr = 32'h0000_0008;
    cyc();
    #1;
    chk("rstmid_iren_pre", {31'd0, bus.iREN}, 32'd1);
    #1;
    nrst = 1'b0;
    #1;
    chk("rstmid_iren", {31'd0, bus.iREN}, 32'd0);
    chk("rstmid_iaddr", bus.iaddr, 32'd0);
    chk("rstmid_cnt", {16'd0, miss_count}, 32'd0);
    cyc();
    nrst = 1'b1;
    miss_fill("rstmid_refetch", 32'h0000_0008, 0, 32'h3333_0008);
    chk("rstmid_refetch_cnt", {16'd0, miss_count}, 32'd1);
    cyc();
    bus.imemaddr = 32'h0000_0004;
    #1;
    chk("rstmid_old_miss", {31'd0, bus.ihit}, 32'd0);
    bus.imemREN = 1'b0;

    // Counter wrap: preload 0xFFFF while idle, then one more fill.
    cyc();
    cyc();
    force dut.miss_count_q = 16'hFFFF;
    cyc();
    release dut.miss_count_q;
    cyc();
    #1;
    chk("wrap_pre", {16'd0, miss_count}, 32'h0000_FFFF);
    miss_fill("wrap", 32'h0000_000C, 0, 32'h4444_000C);
    chk("wrap_cnt", {16'd0, miss_count}, 32'd0);

    cyc();
    bus.imemREN = 1'b0;
    cyc();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
